// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: control bundle layout and datapath
// payload field positions used by every pipe_stage_reg instance.
package cpu_pkg;

    localparam int CPU_DATA_W = 96;
    localparam int CPU_CTRL_W = 16;

    localparam int CTRL_S_B_LSB       = 0;
    localparam int CTRL_S_DATA_W_LSB  = 2;
    localparam int CTRL_ALUOP_LSB     = 4;
    localparam int CTRL_MEM_WRITE_BIT = 8;
    localparam int CTRL_REG_WRITE_BIT = 9;
    localparam int CTRL_S_NPC_LSB     = 10;
    localparam int CTRL_S_NUM_W_LSB   = 12;
    localparam int CTRL_MEM_READ_BIT  = 14;

    typedef struct packed {
        logic       rsvd;
        logic       mem_read;
        logic [1:0] s_num_write;
        logic [1:0] s_npc;
        logic       reg_write;
        logic       mem_write;
        logic [3:0] aluop;
        logic [1:0] s_data_write;
        logic [1:0] s_b;
    } ctrl_t;

    localparam int DATA_NPC_LSB   = 0;
    localparam int DATA_NPC_W     = 32;
    localparam int DATA_IMM_LSB   = 32;
    localparam int DATA_IMM_W     = 32;
    localparam int DATA_RS1_LSB   = 64;
    localparam int DATA_RS2_LSB   = 69;
    localparam int DATA_RD_LSB    = 74;
    localparam int DATA_REG_W     = 5;
    localparam int DATA_SHAMT_LSB = 79;
    localparam int DATA_SHAMT_W   = 5;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline slot: valid flag plus payload and control, with
// clear (zero everything), load, and kill (drop valid, keep payload).
module pipe_entry #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic              kill,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = '0;
            ctrl_d  = '0;
        end else if (ld) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (kill) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// flush, bubble control gating and a saturating stall counter.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int CTRL_W  = CPU_CTRL_W,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              head_v, skid_v;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic              drain, accept;
    logic              head_ld, head_kill;
    logic [DATA_W-1:0] head_din;
    logic [CTRL_W-1:0] head_cin;

    assign drain  = head_v & out_ready;
    assign accept = in_valid & in_ready;

    // A full skid implies a full head, so skid always refills head first.
    always_comb begin
        head_ld   = 1'b0;
        head_kill = 1'b0;
        head_din  = in_data;
        head_cin  = in_ctrl;
        if (!flush) begin
            if (skid_v && drain) begin
                head_ld  = 1'b1;
                head_din = skid_data;
                head_cin = skid_ctrl;
            end else if (accept && (!head_v || drain)) begin
                head_ld = 1'b1;
            end else if (drain) begin
                head_kill = 1'b1;
            end
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clock   (clock),
        .reset   (reset),
        .clr     (flush),
        .ld      (head_ld),
        .kill    (head_kill),
        .in_data (head_din),
        .in_ctrl (head_cin),
        .valid   (head_v),
        .data    (head_data),
        .ctrl    (head_ctrl)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic skid_ld, skid_kill, skid_nxt;
            logic rdy_d, rdy_q;

            assign skid_ld   = !flush & accept & head_v & !drain;
            assign skid_kill = !flush & skid_v & drain;

            always_comb begin
                skid_nxt = skid_v;
                if (flush)
                    skid_nxt = 1'b0;
                else if (skid_ld)
                    skid_nxt = 1'b1;
                else if (skid_kill)
                    skid_nxt = 1'b0;
                rdy_d = !skid_nxt;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    rdy_q <= 1'b1;
                else
                    rdy_q <= rdy_d;
            end

            assign in_ready = rdy_q;

            pipe_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clock   (clock),
                .reset   (reset),
                .clr     (flush),
                .ld      (skid_ld),
                .kill    (skid_kill),
                .in_data (in_data),
                .in_ctrl (in_ctrl),
                .valid   (skid_v),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );
        end else begin : g_flat
            assign skid_v    = 1'b0;
            assign skid_data = '0;
            assign skid_ctrl = '0;
            assign in_ready  = !head_v | out_ready;
        end
    endgenerate

    assign out_valid = head_v;
    assign out_data  = head_data;
    assign out_ctrl  = head_v ? head_ctrl : '0;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr)
            stall_cnt_d = '0;
        else if (head_v && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-buffered stage (CNT_W=4) and single-entry stage
// driven side by side, checked with immediate assertions.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s_in_valid, s_in_ready, s_flush, s_out_valid;
    logic          s_out_ready, s_stall_clr;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [CW-1:0] s_in_ctrl, s_out_ctrl;
    logic [3:0]    s_stall_cnt;

    logic          f_in_valid, f_in_ready, f_flush, f_out_valid;
    logic          f_out_ready, f_stall_clr;
    logic [DW-1:0] f_in_data, f_out_data;
    logic [CW-1:0] f_in_ctrl, f_out_ctrl;
    logic [15:0]   f_stall_cnt;

    int checks = 0;
    int failures = 0;

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .SKID_EN (1'b1), .CNT_W (4)
    ) u_skid (
        .clock     (clk),
        .reset     (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_ctrl   (s_in_ctrl),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_ctrl  (s_out_ctrl),
        .stall_cnt (s_stall_cnt),
        .stall_clr (s_stall_clr)
    );

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .SKID_EN (1'b0), .CNT_W (16)
    ) u_flat (
        .clock     (clk),
        .reset     (rst),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .in_data   (f_in_data),
        .in_ctrl   (f_in_ctrl),
        .flush     (f_flush),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .out_data  (f_out_data),
        .out_ctrl  (f_out_ctrl),
        .stall_cnt (f_stall_cnt),
        .stall_clr (f_stall_clr)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit          ev;
    logic [DW-1:0] ed;
    int          idx, rx, stalls;
    bit          pop, push;

    initial begin
        rst = 1'b0;
        s_in_valid = 1'b1; s_in_data = 96'h1234; s_in_ctrl = 16'h00A5;
        s_flush = 1'b0; s_out_ready = 1'b1; s_stall_clr = 1'b0;
        f_in_valid = 1'b0; f_in_data = '0; f_in_ctrl = '0;
        f_flush = 1'b0; f_out_ready = 1'b1; f_stall_clr = 1'b0;

        tick();
        chk("rst_in_ready", s_in_ready, 1);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_ctrl", s_out_ctrl, 0);
        chk("rst_out_data", s_out_data, 0);
        chk("rst_stall", s_stall_cnt, 0);
        chk("rst_flat_ready", f_in_ready, 1);
        chk("rst_flat_valid", f_out_valid, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("first_valid", s_out_valid, 1);
        chk("first_data", s_out_data, 96'h1234);
        chk("first_ctrl", s_out_ctrl, 16'h00A5);
        s_in_valid = 1'b0;
        tick();
        chk("bubble_valid", s_out_valid, 0);
        chk("bubble_ctrl", s_out_ctrl, 0);
        chk("bubble_data_hold", s_out_data, 96'h1234);

        // streaming at full rate
        s_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_in_data = DW'(100 + i);
            s_in_ctrl = CW'(16'h0200 + i);
            tick();
            chk("stream_valid", s_out_valid, 1);
            chk("stream_data", s_out_data, DW'(100 + i));
        end
        s_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", s_out_valid, 0);
        chk("stream_stall", s_stall_cnt, 0);

        // backpressure into skid
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 96'hA; s_in_ctrl = 16'h000A;
        tick();
        chk("skid_a_valid", s_out_valid, 1);
        chk("skid_a_data", s_out_data, 96'hA);
        chk("skid_a_ready", s_in_ready, 1);
        s_in_data = 96'hB; s_in_ctrl = 16'h000B;
        tick();
        chk("skid_b_ready", s_in_ready, 0);
        chk("skid_b_head", s_out_data, 96'hA);
        chk("skid_b_stall", s_stall_cnt, 1);
        s_in_data = 96'hC; s_in_ctrl = 16'h000C;
        tick();
        chk("skid_c_ready", s_in_ready, 0);
        chk("skid_c_head", s_out_data, 96'hA);
        tick();
        chk("skid_stall3", s_stall_cnt, 3);
        s_out_ready = 1'b1;
        tick();
        chk("drain_b_data", s_out_data, 96'hB);
        chk("drain_b_ctrl", s_out_ctrl, 16'h000B);
        chk("drain_b_ready", s_in_ready, 1);
        tick();
        chk("drain_c_valid", s_out_valid, 1);
        chk("drain_c_data", s_out_data, 96'hC);
        chk("drain_c_ctrl", s_out_ctrl, 16'h000C);
        s_in_valid = 1'b0;
        tick();
        chk("drain_end_valid", s_out_valid, 0);
        chk("drain_stall", s_stall_cnt, 3);

        // flush with both entries full, plus stall_clr
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 96'h11; s_in_ctrl = 16'h0011;
        tick();
        s_in_data = 96'h22; s_in_ctrl = 16'h0022;
        tick();
        chk("full_ready", s_in_ready, 0);
        s_flush = 1'b1; s_stall_clr = 1'b1;
        s_in_data = 96'hD; s_in_ctrl = 16'h000D;
        tick();
        chk("flush_valid", s_out_valid, 0);
        chk("flush_ctrl", s_out_ctrl, 0);
        chk("flush_data", s_out_data, 0);
        chk("flush_ready", s_in_ready, 1);
        chk("flush_stall", s_stall_cnt, 0);
        s_flush = 1'b0; s_stall_clr = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        tick();
        chk("flush_no_d", s_out_valid, 0);
        tick();
        chk("flush_no_d2", s_out_valid, 0);

        // stall counter saturation
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 96'hE; s_in_ctrl = 16'h000E;
        tick();
        s_in_valid = 1'b0;
        repeat (21) tick();
        chk("sat_stall", s_stall_cnt, 15);
        s_stall_clr = 1'b1;
        tick();
        chk("sat_clr", s_stall_cnt, 0);
        s_stall_clr = 1'b0; s_out_ready = 1'b1;
        tick();
        chk("sat_drained", s_out_valid, 0);
        chk("sat_data_hold", s_out_data, 96'hE);
        chk("sat_after", s_stall_cnt, 0);

        // single-entry stage with alternating out_ready
        ev = 1'b0; ed = '0; idx = 0; rx = 0; stalls = 0;
        for (int c = 0; c < 18; c++) begin
            f_out_ready = (c % 2 == 0);
            f_in_valid  = (idx < 6);
            f_in_data   = DW'(32'h50 + idx);
            f_in_ctrl   = CW'(16'h0100 + idx);
            #1;
            chk("flat_ready", f_in_ready, !ev || f_out_ready);
            chk("flat_valid", f_out_valid, ev);
            if (ev) chk("flat_data", f_out_data, ed);
            pop  = ev && f_out_ready;
            push = f_in_valid && (!ev || f_out_ready);
            if (pop) begin
                chk("flat_order", f_out_data, DW'(32'h50 + rx));
                rx++;
            end
            if (ev && !f_out_ready) stalls++;
            if (push) begin
                ev = 1'b1;
                ed = DW'(32'h50 + idx);
                idx++;
            end else if (pop) begin
                ev = 1'b0;
            end
            tick();
        end
        chk("flat_final_valid", f_out_valid, 0);
        chk("flat_stall", f_stall_cnt, DW'(stalls));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
